copy_engine_ctrl: RTL
=====================

Name: copy_engine_ctrl

Overview:
- Sequencer for the sprite copy engine datapath.
- Takes one blit command (source base address, sprite size, destination origin, palette) and walks the sprite row-major.
- For each pixel: drives the source address, captures the source word after a fixed read latency, and issues one frame-buffer program write at the clipped screen coordinate.
- Sits between the NIOS-side command registers and the SRAM/frame-buffer programming port; reports busy/done back to software.

Parameters:
- H_RES, 640, screen width in pixels; writes with x >= H_RES are suppressed.
- V_RES, 480, screen height in pixels; writes with y >= V_RES are suppressed.
- RD_LAT, 2, cycles from src_addr change to valid src_data (legal range 1..7).

Ports:
- clk_clk  in  1  system clock.
- reset_reset_n  in  1  synchronous active-low reset.
- engine_execute  in  1  start pulse; sampled only in IDLE or DONE.
- src_base  in  20  word address of sprite pixel (0,0).
- sprite_w  in  10  sprite width in pixels.
- sprite_h  in  10  sprite height in pixels.
- dst_x  in  10  screen x of sprite origin.
- dst_y  in  10  screen y of sprite origin.
- palette_in  in  2  palette select for this blit.
- src_addr  out  20  source word address.
- src_data  in  16  source pixel word.
- program_x  out  10  frame-buffer write x.
- program_y  out  10  frame-buffer write y.
- program_data  out  16  frame-buffer write data.
- program_write  out  1  write strobe.
- program_grant  in  1  arbiter grant; a write completes only on a cycle with program_write=1 and program_grant=1.
- palette_index  out  2  latched palette for the active blit.
- engine_busy  out  1  high from accept until DONE.
- engine_done  out  1  high in DONE; stays high until the next accepted execute.

Behaviour:
- Reset values: all outputs 0; state IDLE.
- Reset wins over every other event, including mid-blit. No further writes after reset asserts.
- Command acceptance:
  - engine_execute=1 in IDLE/DONE latches all command inputs and sets row=col=0.
  - Latched palette drives palette_index.
  - engine_done clears and engine_busy sets on the next edge.
  - engine_execute while busy is ignored.
- Zero-size command: sprite_w==0 or sprite_h==0 goes straight to DONE one cycle after accept, with no fetch and no write.
- States:
  - IDLE: wait for engine_execute.
  - FETCH:
    - src_addr = base + row*sprite_w + col (20-bit, wraps mod 2^20).
    - Maintain the address with an incrementing register; no multiplier.
    - Load the wait counter with RD_LAT, then go to WAIT.
  - WAIT:
    - Decrement the counter; src_addr is held.
    - At zero, capture src_data into program_data.
    - Compute px = dst_x+col and py = dst_y+row at 11 bits.
    - If px < H_RES and py < V_RES, go to WRITE. Otherwise go to ADV (clipped pixel, no write).
  - WRITE:
    - program_write=1, with program_x/program_y = px/py truncated to 10 bits.
    - Hold all three program outputs stable while program_grant=0.
    - On grant, go to ADV; program_write drops the following cycle.
  - ADV:
    - col+1. At col == sprite_w-1: col=0, row+1.
    - At the last pixel (row == sprite_h-1 and col == sprite_w-1), go to DONE. Otherwise go to FETCH.
  - DONE: engine_busy=0, engine_done=1. engine_execute restarts the engine exactly as from IDLE.
- Throughput: RD_LAT+3 cycles per written pixel with continuous grant; RD_LAT+2 per clipped pixel.
- Inputs sampled after accept do not affect the running blit.
- program_write is never asserted outside WRITE.

Optional Feature:
- Macro: COPY_ENGINE_TRANSPARENT_EN.
- Defined:
  - In WAIT, a captured src_data equal to 16'h0000 is treated as transparent: go to ADV with no write, same timing as a clipped pixel.
- Undefined:
  - Every on-screen pixel is written, including 16'h0000.

Test Plan:
- Reset mid-blit: 4x4 blit, assert reset_reset_n=0 on pixel 5 → next cycle all outputs 0, no further program_write; a new execute then runs from pixel 0.
- Basic blit: src_base=0x00100, 2x2 sprite at (10,20), RD_LAT=2, grant tied 1 → exactly 4 writes to (10,20),(11,20),(10,21),(11,21) carrying memory words 0x100..0x103; 5-cycle spacing; engine_done rises and stays high.
- Clipping: 4x1 sprite at (638,479) → writes only (638,479) and (639,479); 4 fetches still issued; done asserted.
- Grant stall: 1x1 blit with grant low for 6 cycles in WRITE → program_write, x, y and data held constant for 7 cycles; exactly one write completes.
- Zero/busy: sprite_w=0 → done one cycle after accept with no src_addr change and no writes; an execute pulse during a 3x3 blit is ignored (9 writes total).
- Transparency (macro defined): 3x1 sprite with data 0x1234, 0x0000, 0x5678 → writes only x+0 and x+2. With macro undefined → 3 writes.

Source files
------------

// File: rtl/copy_engine_ctrl.sv
// Sprite copy engine sequencer: walks one blit command row-major, fetching each source word and
// issuing a clipped frame-buffer write. Define COPY_ENGINE_TRANSPARENT_EN to skip 16'h0000 words.
//   state   | meaning
//   IDLE    | waiting for engine_execute
//   FETCH   | src_addr valid, load read-latency counter
//   WAIT    | counting down read latency, capture word at zero
//   WRITE   | program_write held until program_grant
//   ADV     | step col/row and source address
//   DONE    | blit finished, engine_done high
module copy_engine_ctrl #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int RD_LAT = 2
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        engine_execute,
  input  logic [19:0] src_base,
  input  logic [9:0]  sprite_w,
  input  logic [9:0]  sprite_h,
  input  logic [9:0]  dst_x,
  input  logic [9:0]  dst_y,
  input  logic [1:0]  palette_in,
  output logic [19:0] src_addr,
  input  logic [15:0] src_data,
  output logic [9:0]  program_x,
  output logic [9:0]  program_y,
  output logic [15:0] program_data,
  output logic        program_write,
  input  logic        program_grant,
  output logic [1:0]  palette_index,
  output logic        engine_busy,
  output logic        engine_done
);

  localparam logic [10:0] H_LIM = 11'(H_RES);
  localparam logic [10:0] V_LIM = 11'(V_RES);
  localparam logic [2:0]  LAT   = 3'(RD_LAT);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_WRITE, S_ADV, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [19:0] addr_q, addr_d;
  logic [9:0]  w_q, w_d, h_q, h_d, dx_q, dx_d, dy_q, dy_d;
  logic [9:0]  col_q, col_d, row_q, row_d;
  logic [9:0]  px_q, px_d, py_q, py_d;
  logic [15:0] pd_q, pd_d;
  logic [1:0]  pal_q, pal_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [10:0] px_full, py_full;
  logic        on_screen, keep_pixel, last_col, last_row;

  assign px_full   = {1'b0, dx_q} + {1'b0, col_q};
  assign py_full   = {1'b0, dy_q} + {1'b0, row_q};
  assign on_screen = (px_full < H_LIM) && (py_full < V_LIM);
  assign last_col  = (col_q == w_q - 10'd1);
  assign last_row  = (row_q == h_q - 10'd1);

`ifdef COPY_ENGINE_TRANSPARENT_EN
  assign keep_pixel = on_screen && (src_data != 16'h0000);
`else
  assign keep_pixel = on_screen;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    w_d     = w_q;
    h_d     = h_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    pal_d   = pal_q;
    col_d   = col_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    px_d    = px_q;
    py_d    = py_q;
    pd_d    = pd_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (engine_execute) begin
          w_d   = sprite_w;
          h_d   = sprite_h;
          dx_d  = dst_x;
          dy_d  = dst_y;
          pal_d = palette_in;
          col_d = '0;
          row_d = '0;
          // zero-size blits never touch the source bus
          if (sprite_w == 10'd0 || sprite_h == 10'd0) begin
            state_d = S_DONE;
          end else begin
            addr_d  = src_base;
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        cnt_d   = LAT;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          pd_d    = src_data;
          px_d    = px_full[9:0];
          py_d    = py_full[9:0];
          state_d = keep_pixel ? S_WRITE : S_ADV;
        end
      end
      S_WRITE: begin
        if (program_grant) state_d = S_ADV;
      end
      S_ADV: begin
        if (last_col) begin
          col_d = '0;
          row_d = row_q + 10'd1;
        end else begin
          col_d = col_q + 10'd1;
        end
        if (last_col && last_row) begin
          state_d = S_DONE;
        end else begin
          addr_d  = addr_q + 20'd1;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      w_q     <= '0;
      h_q     <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      pal_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      cnt_q   <= '0;
      px_q    <= '0;
      py_q    <= '0;
      pd_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      w_q     <= w_d;
      h_q     <= h_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      pal_q   <= pal_d;
      col_q   <= col_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      px_q    <= px_d;
      py_q    <= py_d;
      pd_q    <= pd_d;
    end
  end

  assign src_addr      = addr_q;
  assign program_x     = px_q;
  assign program_y     = py_q;
  assign program_data  = pd_q;
  assign palette_index = pal_q;
  assign program_write = (state_q == S_WRITE);
  assign engine_done   = (state_q == S_DONE);
  assign engine_busy   = (state_q == S_FETCH) || (state_q == S_WAIT) ||
                         (state_q == S_WRITE) || (state_q == S_ADV);

endmodule
